// File: rtl/readout_pkg.sv
// Shared types and constants for the capture-memory readout block.
package readout_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    // One extra bit so a full-depth dump (DEPTH samples) is representable.
    typedef logic [ADDR_WIDTH:0]   cnt_t;

    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);
    localparam cnt_t LAST_IDX = cnt_t'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Read address advance; wraps from all-ones back to zero.
    function automatic addr_t addr_inc(input addr_t a);
        return a + addr_t'(1);
    endfunction

endpackage

// File: rtl/readout_if.sv
// Sample stream between the readout block and its downstream consumer.
interface readout_if;
    import readout_pkg::*;

    data_t o_data;
    logic  o_valid;
    logic  o_last;
    logic  i_ready;

    modport master (output o_data, output o_valid, output o_last, input i_ready);
    modport slave  (input o_data, input o_valid, input o_last, output i_ready);

endinterface

// File: rtl/readout_skid.sv
// Two-entry output buffer: head register drives the stream, tail absorbs
// one extra sample so the read pipeline can keep running while downstream
// stalls. The head only changes on a transfer or while empty, which keeps
// o_data/o_last stable during back-pressure.
module readout_skid
    import readout_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  data_t      push_data,
    input  logic       push_last,
    output logic [1:0] count,
    output logic       pop,
    readout_if.master  stream
);

    logic [1:0] cnt_q;
    data_t      tail_data;
    logic       tail_last;

    assign count = cnt_q;
    assign pop   = stream.o_valid && stream.i_ready;

    // Occupancy, head and tail update on push/pop; flush empties the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q          <= 2'd0;
            stream.o_valid <= 1'b0;
            stream.o_last  <= 1'b0;
            stream.o_data  <= '0;
            tail_data      <= '0;
            tail_last      <= 1'b0;
        end else if (flush) begin
            cnt_q          <= 2'd0;
            stream.o_valid <= 1'b0;
            stream.o_last  <= 1'b0;
        end else begin
            case ({pop, push})
                2'b01: begin
                    if (cnt_q == 2'd0) begin
                        stream.o_data  <= push_data;
                        stream.o_last  <= push_last;
                        stream.o_valid <= 1'b1;
                        cnt_q          <= 2'd1;
                    end else begin
                        tail_data <= push_data;
                        tail_last <= push_last;
                        cnt_q     <= 2'd2;
                    end
                end
                2'b10: begin
                    if (cnt_q == 2'd2) begin
                        stream.o_data <= tail_data;
                        stream.o_last <= tail_last;
                        cnt_q         <= 2'd1;
                    end else begin
                        stream.o_valid <= 1'b0;
                        stream.o_last  <= 1'b0;
                        cnt_q          <= 2'd0;
                    end
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        stream.o_data <= tail_data;
                        stream.o_last <= tail_last;
                        tail_data     <= push_data;
                        tail_last     <= push_last;
                    end else begin
                        stream.o_data <= push_data;
                        stream.o_last <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/readout.sv
// Capture-memory readout: once capture stops, reads the whole memory from
// the oldest sample upward and streams it out with valid/ready handshake.
//
// Read pipeline: raddr is registered (stage p1), memory returns data one
// cycle later (stage p2) and the skid buffer captures it. raddr is held
// whenever no read issues, so a p2 sample stays on rdata until the skid has
// room -- the memory output acts as a parking slot, which is what allows a
// 2-entry skid to sustain one sample per cycle.
module readout
    import readout_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      stopped,
    input  addr_t     waddr,
    output addr_t     raddr,
    input  data_t     rdata,
    readout_if.master stream,
    output logic      o_done
);

    state_t     state;
    cnt_t       rd_cnt;
    cnt_t       xfer_cnt;
    logic       vld_p1;
    logic       vld_p2;
    logic       last_p1;
    logic       last_p2;

    logic [1:0] skid_count;
    logic [1:0] cnt_next;
    logic       skid_pop;
    logic       active;
    logic       run;
    logic       abort;
    logic       room;
    logic       push;
    logic       hold;
    logic       issue;

    // Push/issue decisions for the read pipeline.
    always_comb begin
        active   = (state == FETCH) || (state == STREAM);
        run      = active && stopped;
        abort    = active && !stopped;
        room     = (skid_count != 2'd2) || skid_pop;
        push     = run && vld_p2 && room;
        hold     = vld_p2 && !room;
        cnt_next = skid_count;
        if (push && !skid_pop) begin
            cnt_next = skid_count + 2'd1;
        end else if (!push && skid_pop) begin
            cnt_next = skid_count - 2'd1;
        end
        // A read issued while p1 is occupied forces the p1 sample to be
        // pushed next cycle, so the skid must have a free slot by then.
        issue    = run && (rd_cnt < FULL_CNT) && !hold && (!vld_p1 || cnt_next <= 2'd1);
    end

    // Control FSM, address generator and read/transfer counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            raddr    <= '0;
            rd_cnt   <= '0;
            xfer_cnt <= '0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            last_p1  <= 1'b0;
            last_p2  <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (stopped) begin
                        state    <= FETCH;
                        raddr    <= waddr;
                        rd_cnt   <= cnt_t'(1);
                        xfer_cnt <= '0;
                        vld_p1   <= 1'b1;
                        last_p1  <= (DEPTH == 1);
                        vld_p2   <= 1'b0;
                    end
                end
                FETCH, STREAM: begin
                    if (abort) begin
                        state    <= IDLE;
                        rd_cnt   <= '0;
                        xfer_cnt <= '0;
                        vld_p1   <= 1'b0;
                        vld_p2   <= 1'b0;
                        o_done   <= 1'b0;
                    end else begin
                        state <= STREAM;
                        if (issue) begin
                            raddr   <= addr_inc(raddr);
                            rd_cnt  <= rd_cnt + cnt_t'(1);
                            last_p1 <= (rd_cnt == LAST_IDX);
                        end
                        vld_p1 <= issue;
                        vld_p2 <= vld_p1 || hold;
                        if (vld_p1) begin
                            last_p2 <= last_p1;
                        end
                        if (skid_pop) begin
                            xfer_cnt <= xfer_cnt + cnt_t'(1);
                            if (xfer_cnt == LAST_IDX) begin
                                state  <= DONE;
                                o_done <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!stopped) begin
                        state  <= IDLE;
                        o_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    readout_skid u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort),
        .push      (push),
        .push_data (rdata),
        .push_last (last_p2),
        .count     (skid_count),
        .pop       (skid_pop),
        .stream    (stream)
    );

endmodule
